mcs4_bus_master: RTL and testbench

//  Initiator end of the 4-bit multiplexed MCS-4 bus (data/sync/rom_cmd/ram_cmd_n).
//  - Generates the 8-phase instruction cycle A1 A2 A3 M1 M2 X1 X2 X3.
//  - Turns valid/ready byte-read requests into ROM fetch cycles and returns the fetched byte.
//  - Used as a CPU-less loader/test initiator against the existing rom/ram responders.

---
 rtl/mcs4_bus_master_pkg.sv | 29 ++
 rtl/mcs4_phase_counter.sv | 27 ++
 rtl/mcs4_bus_master.sv | 129 ++++++++++++
 tb/tb_mcs4_bus_master.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcs4_bus_master_pkg.sv
// Shared MCS-4 bus definitions: the instruction-cycle phase encoding, address width,
// and the helper that selects which address nibble is driven in each A-phase.
package mcs4_bus_master_pkg;

  localparam int MCS4_ADDR_W = 12;

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_e;

  // Address goes out low nibble first; non-address phases yield zero.
  function automatic logic [3:0] addr_nibble(input logic [MCS4_ADDR_W-1:0] addr,
                                             input phase_e ph);
    case (ph)
      PH_A1:   return addr[3:0];
      PH_A2:   return addr[7:4];
      PH_A3:   return addr[11:8];
      default: return 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/mcs4_phase_counter.sv
// Free-running 8-phase instruction-cycle counter (A1..X3) with the sync decode.
// It never stalls; the bus master derives all timing from phase/next_phase.
module mcs4_phase_counter
  import mcs4_bus_master_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  output phase_e phase,
  output phase_e next_phase,
  output logic   sync
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase <= PH_A1;
    end else begin
      phase <= next_phase;
    end
  end

  // X3 -> A1 wrap falls out of the 3-bit overflow.
  always_comb begin
    next_phase = phase_e'(phase + 3'd1);
    sync       = (phase == PH_X3);
  end

endmodule

// File: rtl/mcs4_bus_master.sv
// Initiator end of the 4-bit multiplexed MCS-4 bus: turns byte-read requests into ROM
// fetch cycles. Define MCS4_SRC_EN to add SRC cycles (req_src/req_bank, RAM selects in X2).
module mcs4_bus_master
  import mcs4_bus_master_pkg::*;
#(
  parameter int                     RAM_BANKS = 4,
  parameter logic [MCS4_ADDR_W-1:0] IDLE_ADDR = 12'h000
) (
  input  logic                   clock,
  input  logic                   reset,
  inout  wire  [3:0]             data,
  output logic                   sync,
  output logic                   rom_cmd,
  output logic [RAM_BANKS-1:0]   ram_cmd_n,
  input  logic                   req_valid,
  input  logic [MCS4_ADDR_W-1:0] req_addr,
`ifdef MCS4_SRC_EN
  input  logic                   req_src,
  input  logic [1:0]             req_bank,
`endif
  output logic                   req_ready,
  output logic                   rsp_valid,
  output logic [7:0]             rsp_data
);

  phase_e                 phase;
  phase_e                 next_phase;
  logic                   accept;
  logic                   active_q;
  logic                   active_n;
  logic [MCS4_ADDR_W-1:0] addr_q;
  logic [MCS4_ADDR_W-1:0] addr_d;
  logic [MCS4_ADDR_W-1:0] drive_addr;
  logic                   data_oe_q;
  logic [3:0]             data_out_q;
  logic                   oe_d;
  logic [3:0]             out_d;
  logic                   rom_cmd_d;
  logic [3:0]             hi_q;

  mcs4_phase_counter u_phase (
    .clock      (clock),
    .reset      (reset),
    .phase      (phase),
    .next_phase (next_phase),
    .sync       (sync)
  );

  assign data      = data_oe_q ? data_out_q : 4'bz;
  assign req_ready = (phase == PH_X3);
  assign accept    = req_ready && req_valid;

`ifdef MCS4_SRC_EN
  logic                 src_q;
  logic                 src_n;
  logic [1:0]           bank_q;
  logic [RAM_BANKS-1:0] ram_d;

  assign src_n = (phase == PH_X3) ? (accept && req_src) : src_q;
`else
  assign ram_cmd_n = '1;
`endif

  // Bus drive is registered from next_phase so output enable changes exactly on the
  // edge that enters a phase, which keeps the master off the bus for all of M1/M2.
  always_comb begin
    addr_d     = accept ? req_addr : IDLE_ADDR;
    drive_addr = (phase == PH_X3) ? addr_d : addr_q;
    active_n   = (phase == PH_X3) ? accept : active_q;
    oe_d       = (next_phase == PH_A1) || (next_phase == PH_A2) || (next_phase == PH_A3);
    out_d      = addr_nibble(drive_addr, next_phase);
    rom_cmd_d  = active_n && (next_phase == PH_A3);
`ifdef MCS4_SRC_EN
    ram_d = '1;
    if (src_n && (next_phase == PH_X2)) begin
      oe_d          = 1'b1;
      out_d         = drive_addr[7:4];
      rom_cmd_d     = 1'b1;
      ram_d[bank_q] = 1'b0;
    end
    if (src_n && (next_phase == PH_X3)) begin
      oe_d  = 1'b1;
      out_d = drive_addr[3:0];
    end
`endif
  end

  // Requests latch only at the X3->A1 edge; an abandoned cycle simply loses active_q.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active_q   <= 1'b0;
      addr_q     <= IDLE_ADDR;
      data_oe_q  <= 1'b0;
      data_out_q <= 4'h0;
      rom_cmd    <= 1'b0;
      hi_q       <= 4'h0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
`ifdef MCS4_SRC_EN
      src_q      <= 1'b0;
      bank_q     <= 2'd0;
      ram_cmd_n  <= '1;
`endif
    end else begin
      if (phase == PH_X3) begin
        active_q <= accept;
        addr_q   <= addr_d;
`ifdef MCS4_SRC_EN
        src_q    <= accept && req_src;
        bank_q   <= req_bank;
`endif
      end
      data_oe_q  <= oe_d;
      data_out_q <= out_d;
      rom_cmd    <= rom_cmd_d;
`ifdef MCS4_SRC_EN
      ram_cmd_n  <= ram_d;
`endif
      if (active_q && (phase == PH_M1)) begin
        hi_q <= data;
      end
      rsp_valid <= active_q && (phase == PH_M2);
      if (active_q && (phase == PH_M2)) begin
        rsp_data <= {hi_q, data};
      end
    end
  end

endmodule

// File: tb/tb_mcs4_bus_master.sv
// Self-checking bench for mcs4_bus_master: a table of fetch vectors against a small ROM
// responder, plus hand-written sequences for back-to-back, late request and mid-cycle reset.
module tb_mcs4_bus_master;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [11:0] req_addr = 12'h000;
  wire  [3:0]  data;
  logic        sync;
  logic        rom_cmd;
  logic [3:0]  ram_cmd_n;
  logic        req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
`ifdef MCS4_SRC_EN
  logic        req_src = 1'b0;
  logic [1:0]  req_bank = 2'd0;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc = 0;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  exp_byte;
  } vec_t;

  typedef struct {
    int         at;
    logic [7:0] d;
  } rsp_t;

  vec_t       vecs[4];
  rsp_t       rsp_q[$];
  logic [7:0] rom_mem[4096];

  mcs4_bus_master dut (
    .clock     (clock),
    .reset     (reset),
    .data      (data),
    .sync      (sync),
    .rom_cmd   (rom_cmd),
    .ram_cmd_n (ram_cmd_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
`ifdef MCS4_SRC_EN
    .req_src   (req_src),
    .req_bank  (req_bank),
`endif
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // ROM responder: follows sync to know the phase, collects the address from the bus,
  // answers in M1/M2 on every cycle, and parks the bus at 0 whenever the master must be off it.
  logic [2:0]  tb_ph;
  logic [11:0] resp_addr;
  logic        tb_oe;
  logic [3:0]  tb_val;

  always @(posedge clock or negedge reset) begin
    if (!reset) tb_ph <= 3'd0;
    else        tb_ph <= sync ? 3'd0 : tb_ph + 3'd1;
  end

  always @(negedge clock) begin
    if (reset) begin
      case (tb_ph)
        3'd0: resp_addr[3:0]  <= data;
        3'd1: resp_addr[7:4]  <= data;
        3'd2: resp_addr[11:8] <= data;
        default: ;
      endcase
    end
  end

  always_comb begin
    tb_oe  = 1'b0;
    tb_val = 4'h0;
    if (!reset) begin
      tb_oe = 1'b1;
    end else if (tb_ph == 3'd3) begin
      tb_oe  = 1'b1;
      tb_val = rom_mem[resp_addr][7:4];
    end else if (tb_ph == 3'd4) begin
      tb_oe  = 1'b1;
      tb_val = rom_mem[resp_addr][3:0];
    end
`ifndef MCS4_SRC_EN
    else if (tb_ph >= 3'd5) begin
      tb_oe = 1'b1;
    end
`endif
  end

  assign data = tb_oe ? tb_val : 4'bz;

  always @(negedge clock) begin
    if (reset && rsp_valid) rsp_q.push_back('{cyc, rsp_data});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic waitSync();
    int n = 0;
    while (!sync && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!sync) begin
      total++;
      bad++;
      $display("FAIL wait_sync: got=0 exp=1");
    end
  endtask

  // Present a request at X3 and let it be taken on the X3->A1 edge.
  task automatic applyStimulus(input logic [11:0] addr);
    waitSync();
    req_valid = 1'b1;
    req_addr  = addr;
    checkOutput("req_ready_at_x3", req_ready, 1'b1);
    @(posedge clock);
    #1;
    acc       = cyc;
    req_valid = 1'b0;
    req_addr  = 12'h5A5;
  endtask

  function automatic logic [3:0] nib(input logic [11:0] a, input int k);
    logic [3:0] r;
    case (k)
      0:       r = a[3:0];
      1:       r = a[7:4];
      default: r = a[11:8];
    endcase
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = 8'h00;
    rom_mem[12'h0A5] = 8'h3C;
    rom_mem[12'h800] = 8'hE2;
    rom_mem[12'hFFF] = 8'h5B;
    rom_mem[12'h034] = 8'hC4;
    rom_mem[12'h001] = 8'h91;
    rom_mem[12'h002] = 8'h7E;

    vecs[0] = '{12'h0A5, 8'h3C};
    vecs[1] = '{12'h800, 8'hE2};
    vecs[2] = '{12'hFFF, 8'h5B};
    vecs[3] = '{12'h034, 8'hC4};

    // Reset state and first sync seven clocks after release.
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_sync", sync, 1'b0);
    checkOutput("rst_rom_cmd", rom_cmd, 1'b0);
    checkOutput("rst_ram_cmd_n", ram_cmd_n, 4'hF);
    checkOutput("rst_req_ready", req_ready, 1'b0);
    checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("rst_rsp_data", rsp_data, 8'h00);
    checkOutput("rst_data", data, 4'h0);
    reset = 1'b1;
    $display("[TB] reset released");
    for (int i = 1; i <= 23; i++) begin
      @(negedge clock);
      checkOutput($sformatf("idle_sync_%0d", i), sync, (i % 8) == 7);
      checkOutput($sformatf("idle_rom_cmd_%0d", i), rom_cmd, 1'b0);
      checkOutput($sformatf("idle_rsp_valid_%0d", i), rsp_valid, 1'b0);
    end

    // Table of fetches, issued back-to-back, checked phase by phase.
    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].addr);
      for (int k = 0; k < 8; k++) begin
        @(negedge clock);
        checkOutput($sformatf("v%0d_k%0d_sync", v, k), sync, k == 7);
        checkOutput($sformatf("v%0d_k%0d_rom_cmd", v, k), rom_cmd, k == 2);
        checkOutput($sformatf("v%0d_k%0d_rsp_valid", v, k), rsp_valid, k == 5);
        checkOutput($sformatf("v%0d_k%0d_ram_cmd_n", v, k), ram_cmd_n, 4'hF);
        if (k < 3) checkOutput($sformatf("v%0d_k%0d_data", v, k), data, nib(vecs[v].addr, k));
        if (k == 3) checkOutput($sformatf("v%0d_m1_data", v), data, vecs[v].exp_byte[7:4]);
        if (k == 4) checkOutput($sformatf("v%0d_m2_data", v), data, vecs[v].exp_byte[3:0]);
        if (k >= 5) checkOutput($sformatf("v%0d_k%0d_rsp_data", v, k), rsp_data, vecs[v].exp_byte);
`ifndef MCS4_SRC_EN
        if (k >= 5) checkOutput($sformatf("v%0d_k%0d_x_data", v, k), data, 4'h0);
`endif
      end
    end

    // req_valid held across two X3 edges: two active cycles with no idle one between.
    waitSync();
    rsp_q.delete();
    req_valid = 1'b1;
    req_addr  = 12'h001;
    @(posedge clock);
    #1;
    acc      = cyc;
    req_addr = 12'h002;
    repeat (8) @(posedge clock);
    #1;
    req_valid = 1'b0;
    repeat (16) @(negedge clock);
    checkOutput("b2b_count", 12'(rsp_q.size()), 12'd2);
    if (rsp_q.size() >= 2) begin
      checkOutput("b2b_latency", 12'(rsp_q[0].at - acc), 12'd5);
      checkOutput("b2b_spacing", 12'(rsp_q[1].at - rsp_q[0].at), 12'd8);
      checkOutput("b2b_byte0", rsp_q[0].d, 8'h91);
      checkOutput("b2b_byte1", rsp_q[1].d, 8'h7E);
    end

    // Request raised in M2 of an idle cycle waits for X3.
    waitSync();
    rsp_q.delete();
    repeat (5) @(negedge clock);
    req_valid = 1'b1;
    req_addr  = 12'hFFF;
    checkOutput("late_ready_m2", req_ready, 1'b0);
    @(negedge clock);
    checkOutput("late_ready_x1", req_ready, 1'b0);
    @(negedge clock);
    checkOutput("late_ready_x2", req_ready, 1'b0);
    @(negedge clock);
    checkOutput("late_ready_x3", req_ready, 1'b1);
    checkOutput("late_no_rsp_yet", 12'(rsp_q.size()), 12'd0);
    @(posedge clock);
    #1;
    acc       = cyc;
    req_valid = 1'b0;
    repeat (8) @(negedge clock);
    checkOutput("late_count", 12'(rsp_q.size()), 12'd1);
    if (rsp_q.size() >= 1) begin
      checkOutput("late_latency", 12'(rsp_q[0].at - acc), 12'd5);
      checkOutput("late_byte", rsp_q[0].d, 8'h5B);
    end

    // Reset pulsed in M1 of an active cycle abandons it.
    applyStimulus(12'h800);
    rsp_q.delete();
    repeat (4) @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("midrst_data", data, 4'h0);
    checkOutput("midrst_sync", sync, 1'b0);
    checkOutput("midrst_rom_cmd", rom_cmd, 1'b0);
    checkOutput("midrst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("midrst_rsp_data", rsp_data, 8'h00);
    checkOutput("midrst_req_ready", req_ready, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      checkOutput($sformatf("midrst_sync_%0d", i), sync, i == 7);
    end
    checkOutput("midrst_no_rsp", 12'(rsp_q.size()), 12'd0);

`ifdef MCS4_SRC_EN
    // SRC cycle: bank 2 selected in X2, address nibbles driven in X2/X3.
    waitSync();
    rsp_q.delete();
    req_valid = 1'b1;
    req_addr  = 12'h034;
    req_src   = 1'b1;
    req_bank  = 2'd2;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_src   = 1'b0;
    req_bank  = 2'd0;
    repeat (7) @(negedge clock);
    checkOutput("src_x2_ram_cmd_n", ram_cmd_n, 4'b1011);
    checkOutput("src_x2_rom_cmd", rom_cmd, 1'b1);
    checkOutput("src_x2_data", data, 4'h3);
    @(negedge clock);
    checkOutput("src_x3_data", data, 4'h4);
    checkOutput("src_x3_ram_cmd_n", ram_cmd_n, 4'hF);
    checkOutput("src_count", 12'(rsp_q.size()), 12'd1);
    if (rsp_q.size() >= 1) checkOutput("src_byte", rsp_q[0].d, 8'hC4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
